// File: rtl/sat_engine_ctrl_pkg.sv
// Shared types and width defaults for the Sat Engine sequencing controller
// and the state list it drives.
package sat_engine_ctrl_pkg;

    localparam int WIDTH_LVL_DEF     = 16;
    localparam int WIDTH_BIN_ID_DEF  = 10;
    localparam int WIDTH_CNT_DEF     = 16;
    localparam int MAX_CONFLICTS_DEF = 1000;

    typedef enum logic [1:0] {
        SAT_BIN = 2'd0,
        BKT_BIN = 2'd1,
        UNSAT   = 2'd2,
        ABORT   = 2'd3
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_IMPLY       = 3'd1,
        ST_DECIDE_REQ  = 3'd2,
        ST_DECIDE_WAIT = 3'd3,
        ST_ANALYZE     = 3'd4,
        ST_ANALYZE_REL = 3'd5,
        ST_BKT         = 3'd6,
        ST_FINISH      = 3'd7
    } state_e;

endpackage

// File: rtl/sat_engine_ctrl_if.sv
// Request/acknowledge bundle between the sequencing controller (master), the
// bin manager and the state list (slave). Stats outputs exist only under
// SAT_ENGINE_CTRL_STATS_EN.
interface sat_engine_ctrl_if
    import sat_engine_ctrl_pkg::*;
#(
    parameter int WIDTH_LVL    = WIDTH_LVL_DEF,
    parameter int WIDTH_BIN_ID = WIDTH_BIN_ID_DEF,
    parameter int WIDTH_CNT    = WIDTH_CNT_DEF
);
    logic                    start_i;
    logic [WIDTH_BIN_ID-1:0] cur_bin_num_i;
    logic                    start_decision_o;
    logic                    done_decision_i;
    logic                    decided_any_i;
    logic                    apply_imply_o;
    logic                    done_imply_i;
    logic                    find_conflict_i;
    logic                    apply_analyze_o;
    logic                    add_learntc_en_i;
    logic                    done_analyze_i;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_i;
    logic [WIDTH_LVL-1:0]    bkt_lvl_i;
    logic                    apply_bkt_cur_bin_o;
    logic                    done_bkt_cur_bin_i;
    logic                    done_o;
    logic [1:0]              result_o;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_o;
    logic [WIDTH_LVL-1:0]    bkt_lvl_o;
    logic                    busy_o;
`ifdef SAT_ENGINE_CTRL_STATS_EN
    logic [WIDTH_CNT-1:0]    stat_decisions_o;
    logic [WIDTH_CNT-1:0]    stat_conflicts_o;
    logic [WIDTH_CNT-1:0]    stat_learnts_o;
`endif

    modport master (
`ifdef SAT_ENGINE_CTRL_STATS_EN
        output stat_decisions_o, stat_conflicts_o, stat_learnts_o,
`endif
        output start_decision_o, apply_imply_o, apply_analyze_o,
        output apply_bkt_cur_bin_o, done_o, result_o, bkt_bin_o, bkt_lvl_o, busy_o,
        input  start_i, cur_bin_num_i, done_decision_i, decided_any_i,
        input  done_imply_i, find_conflict_i, add_learntc_en_i, done_analyze_i,
        input  bkt_bin_i, bkt_lvl_i, done_bkt_cur_bin_i
    );

    modport slave (
`ifdef SAT_ENGINE_CTRL_STATS_EN
        input  stat_decisions_o, stat_conflicts_o, stat_learnts_o,
`endif
        input  start_decision_o, apply_imply_o, apply_analyze_o,
        input  apply_bkt_cur_bin_o, done_o, result_o, bkt_bin_o, bkt_lvl_o, busy_o,
        output start_i, cur_bin_num_i, done_decision_i, decided_any_i,
        output done_imply_i, find_conflict_i, add_learntc_en_i, done_analyze_i,
        output bkt_bin_i, bkt_lvl_i, done_bkt_cur_bin_i
    );

endinterface

// File: rtl/sat_ctrl_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_ctrl_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sat_engine_ctrl.sv
// Per-bin CDCL sequencer: imply -> decide -> ... -> analyze -> backtrack until
// SAT, backtrack to an earlier bin, UNSAT or budget abort. Optional counters
// under SAT_ENGINE_CTRL_STATS_EN.
module sat_engine_ctrl
    import sat_engine_ctrl_pkg::*;
#(
    parameter int WIDTH_LVL     = WIDTH_LVL_DEF,
    parameter int WIDTH_BIN_ID  = WIDTH_BIN_ID_DEF,
    parameter int WIDTH_CNT     = WIDTH_CNT_DEF,
    parameter int MAX_CONFLICTS = MAX_CONFLICTS_DEF
) (
    input logic               clk,
    input logic               rst,
    sat_engine_ctrl_if.master bus
);

    localparam bit BUDGET_EN = (MAX_CONFLICTS != 0);

    state_e                  state, state_nxt;
    result_e                 result_q, result_nxt;
    logic                    result_ld;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q;
    logic [WIDTH_LVL-1:0]    bkt_lvl_q;
    logic [WIDTH_CNT-1:0]    conflicts;

    logic accept, conflict_ev, analyze_ack, budget_hit;

    assign accept      = (state == ST_IDLE) && bus.start_i;
    assign conflict_ev = (state == ST_IMPLY) && bus.done_imply_i && bus.find_conflict_i;
    assign analyze_ack = (state == ST_ANALYZE) && bus.done_analyze_i;
    // Counter has already absorbed the current conflict by the time ANALYZE_REL decides.
    assign budget_hit  = BUDGET_EN && (32'(conflicts) >= 32'(MAX_CONFLICTS));

    sat_ctrl_counter #(.WIDTH(WIDTH_CNT)) u_conflicts (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (conflict_ev),
        .cnt (conflicts)
    );

    always_comb begin
        state_nxt  = state;
        result_nxt = result_q;
        result_ld  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start_i) state_nxt = ST_IMPLY;
            end
            ST_IMPLY: begin
                if (bus.done_imply_i)
                    state_nxt = bus.find_conflict_i ? ST_ANALYZE : ST_DECIDE_REQ;
            end
            ST_DECIDE_REQ: begin
                state_nxt = ST_DECIDE_WAIT;
            end
            ST_DECIDE_WAIT: begin
                if (bus.done_decision_i) begin
                    if (bus.decided_any_i) begin
                        state_nxt = ST_IMPLY;
                    end else begin
                        state_nxt  = ST_FINISH;
                        result_nxt = SAT_BIN;
                        result_ld  = 1'b1;
                    end
                end
            end
            ST_ANALYZE: begin
                if (bus.done_analyze_i) state_nxt = ST_ANALYZE_REL;
            end
            ST_ANALYZE_REL: begin
                // apply_analyze_o is low here so the analyzer can drop back to idle.
                if (bkt_lvl_q == '0) begin
                    state_nxt  = ST_FINISH;
                    result_nxt = UNSAT;
                    result_ld  = 1'b1;
                end else if (budget_hit) begin
                    state_nxt  = ST_FINISH;
                    result_nxt = ABORT;
                    result_ld  = 1'b1;
                end else if (bkt_bin_q != bus.cur_bin_num_i) begin
                    state_nxt  = ST_FINISH;
                    result_nxt = BKT_BIN;
                    result_ld  = 1'b1;
                end else begin
                    state_nxt = ST_BKT;
                end
            end
            ST_BKT: begin
                if (bus.done_bkt_cur_bin_i) state_nxt = ST_IMPLY;
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            result_q  <= SAT_BIN;
            bkt_bin_q <= '0;
            bkt_lvl_q <= '0;
        end else begin
            state <= state_nxt;
            if (result_ld) result_q <= result_nxt;
            if (analyze_ack) begin
                bkt_bin_q <= bus.bkt_bin_i;
                bkt_lvl_q <= bus.bkt_lvl_i;
            end
        end
    end

    // All requests decode straight from state, so at most one is ever high.
    assign bus.apply_imply_o       = (state == ST_IMPLY);
    assign bus.start_decision_o    = (state == ST_DECIDE_REQ);
    assign bus.apply_analyze_o     = (state == ST_ANALYZE);
    assign bus.apply_bkt_cur_bin_o = (state == ST_BKT);
    assign bus.done_o              = (state == ST_FINISH);
    assign bus.busy_o              = (state != ST_IDLE);
    assign bus.result_o            = result_q;
    assign bus.bkt_bin_o           = bkt_bin_q;
    assign bus.bkt_lvl_o           = bkt_lvl_q;

`ifdef SAT_ENGINE_CTRL_STATS_EN
    logic counting;
    logic [WIDTH_CNT-1:0] decisions, learnts;

    // Nothing counts in IDLE or FINISH, which freezes the values seen at done_o.
    assign counting = (state != ST_IDLE) && (state != ST_FINISH);

    sat_ctrl_counter #(.WIDTH(WIDTH_CNT)) u_decisions (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc ((state == ST_DECIDE_WAIT) && bus.done_decision_i && bus.decided_any_i),
        .cnt (decisions)
    );

    sat_ctrl_counter #(.WIDTH(WIDTH_CNT)) u_learnts (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (counting && bus.add_learntc_en_i),
        .cnt (learnts)
    );

    assign bus.stat_decisions_o = decisions;
    assign bus.stat_conflicts_o = conflicts;
    assign bus.stat_learnts_o   = learnts;
`endif

endmodule

// File: tb/tb_sat_engine_ctrl.sv
// Scoreboard bench for sat_engine_ctrl: the driver plays the state list from a
// pre-planned script, a monitor checks every done_o against the expected outcome.
module tb_sat_engine_ctrl;
    import sat_engine_ctrl_pkg::*;

    localparam int WL = 16, WB = 10, WC = 16, MAXC = 2;
    localparam int K_IMP = 0, K_DEC = 1, K_ANA = 2, K_BKT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sat_engine_ctrl_if #(.WIDTH_LVL(WL), .WIDTH_BIN_ID(WB), .WIDTH_CNT(WC)) bus ();

    sat_engine_ctrl #(
        .WIDTH_LVL(WL), .WIDTH_BIN_ID(WB), .WIDTH_CNT(WC), .MAX_CONFLICTS(MAXC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int kind; bit flag; int bin; int lvl; bit learnt;
    } step_t;

    typedef struct {
        int res; int bin; int lvl; int dec_pulses; int bkts;
        int s_dec; int s_conf; int s_learn;
    } exp_t;

    step_t steps[$];
    exp_t  sb[$];
    int    forced[$];
    int    tests = 0, fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int rnd);
        if (forced.size() > 0) return forced.pop_front();
        return rnd;
    endfunction

    // Reference model: walks the CDCL rules directly and records the responder script.
    task automatic plan_run(input int cur);
        exp_t  e;
        step_t s;
        int    conf = 0;
        bit    fin = 0;
        e = '{default: 0};
        while (!fin) begin
            s = '{default: 0};
            s.kind = K_IMP;
            s.flag = 1'(pick(($urandom_range(0, 99) < 35) ? 1 : 0));
            steps.push_back(s);
            if (s.flag) begin
                conf++;
                e.s_conf = conf;
                s = '{default: 0};
                s.kind   = K_ANA;
                s.bin    = pick(($urandom_range(0, 2) == 0) ? (cur + $urandom_range(1, 1000)) % 1024 : cur);
                s.lvl    = pick(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30));
                s.learnt = 1'(pick($urandom_range(0, 1)));
                steps.push_back(s);
                if (s.learnt) e.s_learn++;
                e.bin = s.bin;
                e.lvl = s.lvl;
                if (s.lvl == 0) begin
                    e.res = UNSAT; fin = 1;
                end else if (conf >= MAXC) begin
                    e.res = ABORT; fin = 1;
                end else if (s.bin != cur) begin
                    e.res = BKT_BIN; fin = 1;
                end else begin
                    s = '{default: 0};
                    s.kind = K_BKT;
                    steps.push_back(s);
                    e.bkts++;
                end
            end else begin
                e.dec_pulses++;
                s = '{default: 0};
                s.kind = K_DEC;
                s.flag = 1'(pick((e.dec_pulses < 8 && $urandom_range(0, 99) < 80) ? 1 : 0));
                steps.push_back(s);
                if (s.flag) e.s_dec++;
                else begin
                    e.res = SAT_BIN; fin = 1;
                end
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: counts request pulses and checks each done_o against the scoreboard.
    int dec_cnt = 0, bkt_cnt = 0;
    bit prev_bkt = 0, onehot_bad = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            dec_cnt = 0; bkt_cnt = 0; prev_bkt = 0; onehot_bad = 0;
        end else begin
            if (bus.start_decision_o) dec_cnt++;
            if (bus.apply_bkt_cur_bin_o && !prev_bkt) bkt_cnt++;
            prev_bkt = bus.apply_bkt_cur_bin_o;
            if (int'(bus.apply_imply_o) + int'(bus.apply_analyze_o) + int'(bus.apply_bkt_cur_bin_o) > 1)
                onehot_bad = 1;
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_done: done_o=1 with no run outstanding (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("result", int'(bus.result_o), e.res);
                    if (e.res != SAT_BIN) begin
                        check("bkt_bin", int'(bus.bkt_bin_o), e.bin);
                        check("bkt_lvl", int'(bus.bkt_lvl_o), e.lvl);
                    end
                    check("decision_pulses", dec_cnt, e.dec_pulses);
                    check("bkt_requests", bkt_cnt, e.bkts);
                    check("one_hot_apply", int'(onehot_bad), 0);
                    check("busy_at_done", int'(bus.busy_o), 1);
`ifdef SAT_ENGINE_CTRL_STATS_EN
                    check("stat_decisions", int'(bus.stat_decisions_o), e.s_dec);
                    check("stat_conflicts", int'(bus.stat_conflicts_o), e.s_conf);
                    check("stat_learnts", int'(bus.stat_learnts_o), e.s_learn);
`endif
                end
                dec_cnt = 0; bkt_cnt = 0; onehot_bad = 0;
            end
        end
    end

    function automatic bit req(input int k);
        case (k)
            K_IMP:   return bus.apply_imply_o;
            K_DEC:   return bus.start_decision_o;
            K_ANA:   return bus.apply_analyze_o;
            default: return bus.apply_bkt_cur_bin_o;
        endcase
    endfunction

    task automatic wait_req(input int k, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (req(k)) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL request_timeout: kind %0d never requested, expected within 40 cycles", k);
        end
    endtask

    task automatic clear_inputs();
        bus.start_i = 0; bus.done_decision_i = 0; bus.decided_any_i = 0;
        bus.done_imply_i = 0; bus.find_conflict_i = 0; bus.add_learntc_en_i = 0;
        bus.done_analyze_i = 0; bus.bkt_bin_i = '0; bus.bkt_lvl_i = '0;
        bus.done_bkt_cur_bin_i = 0;
    endtask

    task automatic recover();
        clear_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        steps.delete();
        sb.delete();
        @(negedge clk);
    endtask

    task automatic do_run(input int cur);
        step_t s;
        bit    ok;
        int    d;
        bus.cur_bin_num_i = WB'(cur);
        plan_run(cur);
        bus.start_i = 1;
        @(negedge clk);
        bus.start_i = 0;
        check("start_to_imply", int'(bus.apply_imply_o), 1);
        check("busy_after_start", int'(bus.busy_o), 1);
        while (steps.size() > 0) begin
            s = steps.pop_front();
            wait_req(s.kind, ok);
            if (!ok) begin recover(); return; end
            case (s.kind)
                K_IMP: begin
                    d = $urandom_range(0, 2);
                    for (int i = 0; i < d; i++) begin
                        if (i == 0 && $urandom_range(0, 1) == 1) bus.start_i = 1;
                        @(negedge clk);
                        bus.start_i = 0;
                        check("imply_held", int'(bus.apply_imply_o), 1);
                    end
                    bus.done_imply_i = 1; bus.find_conflict_i = s.flag;
                    @(negedge clk);
                    bus.done_imply_i = 0; bus.find_conflict_i = 0;
                    if (s.flag) check("imply_to_analyze", int'(bus.apply_analyze_o), 1);
                    else        check("imply_to_decide", int'(bus.start_decision_o), 1);
                end
                K_DEC: begin
                    @(negedge clk);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    bus.done_decision_i = 1; bus.decided_any_i = s.flag;
                    @(negedge clk);
                    bus.done_decision_i = 0; bus.decided_any_i = 0;
                    if (s.flag) check("decide_to_imply", int'(bus.apply_imply_o), 1);
                    else        check("decide_to_done", int'(bus.done_o), 1);
                end
                K_ANA: begin
                    if (s.learnt) begin
                        bus.add_learntc_en_i = 1;
                        @(negedge clk);
                        bus.add_learntc_en_i = 0;
                    end
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    bus.done_analyze_i = 1; bus.bkt_bin_i = WB'(s.bin); bus.bkt_lvl_i = WL'(s.lvl);
                    @(negedge clk);
                    // Scramble the bus so only the latched values can reach the outputs.
                    bus.done_analyze_i = 0; bus.bkt_bin_i = WB'($urandom); bus.bkt_lvl_i = WL'($urandom);
                    check("analyze_release", int'(bus.apply_analyze_o), 0);
                    check("release_gap", int'(bus.apply_bkt_cur_bin_o | bus.done_o), 0);
                    @(negedge clk);
                    if (steps.size() > 0 && steps[0].kind == K_BKT)
                        check("release_to_bkt", int'(bus.apply_bkt_cur_bin_o), 1);
                    else
                        check("release_to_done", int'(bus.done_o), 1);
                end
                default: begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    bus.done_bkt_cur_bin_i = 1;
                    @(negedge clk);
                    bus.done_bkt_cur_bin_i = 0;
                    check("bkt_drop", int'(bus.apply_bkt_cur_bin_o), 0);
                    check("bkt_to_imply", int'(bus.apply_imply_o), 1);
                end
            endcase
        end
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.busy_o) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy_o still 1, expected 0 within 10 cycles");
            recover();
        end
    endtask

    task automatic reset_mid_run();
        bit ok;
        bus.cur_bin_num_i = WB'(5);
        bus.start_i = 1;
        @(negedge clk);
        bus.start_i = 0;
        wait_req(K_IMP, ok);
        if (!ok) begin recover(); return; end
        bus.done_imply_i = 1; bus.find_conflict_i = 1;
        @(negedge clk);
        bus.done_imply_i = 0; bus.find_conflict_i = 0;
        wait_req(K_ANA, ok);
        if (!ok) begin recover(); return; end
        rst = 0;
        @(negedge clk);
        check("rst_apply_analyze", int'(bus.apply_analyze_o), 0);
        check("rst_apply_any", int'(bus.apply_imply_o | bus.apply_bkt_cur_bin_o | bus.start_decision_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_result", int'(bus.result_o), 0);
        check("rst_bkt_lvl", int'(bus.bkt_lvl_o), 0);
        check("rst_bkt_bin", int'(bus.bkt_bin_o), 0);
        rst = 1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", int'(bus.busy_o), 0);
    endtask

    initial begin
        clear_inputs();
        bus.cur_bin_num_i = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy_o), 0);
        check("reset_done", int'(bus.done_o), 0);
        check("reset_result", int'(bus.result_o), 0);
        check("reset_apply", int'(bus.apply_imply_o | bus.apply_analyze_o | bus.apply_bkt_cur_bin_o), 0);
        rst = 1;
        @(negedge clk);

        // Stray acks while idle must not wake the controller.
        bus.done_imply_i = 1; bus.done_decision_i = 1; bus.done_analyze_i = 1; bus.done_bkt_cur_bin_i = 1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("spurious_idle", int'(bus.busy_o), 0);

        forced = '{0, 1, 0, 1, 0, 0};                         do_run(5);
        forced = '{1, 5, 3, 0, 0, 0};                         do_run(5);
        forced = '{1, 2, 7, 1};                               do_run(5);
        reset_mid_run();
        forced = '{1, 5, 0, 0};                               do_run(5);
        forced = '{1, 5, 4, 1, 1, 5, 4, 1};                   do_run(5);
        forced = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 5, 4, 1, 1, 5, 4, 1}; do_run(5);

        repeat (40) do_run($urandom_range(0, 1023));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
